// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first.
// The result and final borrow are published together after WIDTH RUN cycles.
`timescale 1ns/1ps
module bit_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;

    logic             accept_s;
    logic             last_s;
    logic             d_s;
    logic             br_next_s;
    logic [WIDTH-1:0] res_next_s;

    // Next-state decode and one-bit full-subtractor cell
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        last_s     = (cnt_r == LAST_BIT);
        d_s        = a_sh_r[0] ^ b_sh_r[0] ^ br_r;
        br_next_s  = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & br_r);
        res_next_s = WIDTH'({d_s, res_sh_r} >> 1);
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; busy/done are flopped from the next state so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == RUN);
            done    <= (state_s == DONE);
        end
    end

    // Operand capture, serial shifting and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r     <= {WIDTH{1'b0}};
            b_sh_r     <= {WIDTH{1'b0}};
            res_sh_r   <= {WIDTH{1'b0}};
            br_r       <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            diff       <= {WIDTH{1'b0}};
            borrow_out <= 1'b0;
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            br_r     <= borrow_in;
            res_sh_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            br_r     <= br_next_s;
            res_sh_r <= res_next_s;
            if (last_s) begin
                // Only the completed word is ever exposed on diff
                cnt_r      <= {CW{1'b0}};
                diff       <= res_next_s;
                borrow_out <= br_next_s;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule
